// File: rtl/mcdf_arbiter.sv
// mcdf_arbiter: three-channel priority arbiter feeding one downstream consumer through a registered output stage.
// Build option ARB_RR_TIE_EN: equal-priority ties rotate round-robin; undefined, ties go to the lowest channel index.
module mcdf_arbiter #(
    parameter int FIFO_WIDE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           arb_ch0_priority,
    input  logic [1:0]           arb_ch1_priority,
    input  logic [1:0]           arb_ch2_priority,
    input  logic                 arb_uplink_valid0,
    input  logic                 arb_uplink_valid1,
    input  logic                 arb_uplink_valid2,
    input  logic                 arb_downlink_valid,
    input  logic [FIFO_WIDE-1:0] arb_ch0_data_in,
    input  logic [FIFO_WIDE-1:0] arb_ch1_data_in,
    input  logic [FIFO_WIDE-1:0] arb_ch2_data_in,
    output logic                 arb_downlink_ready,
    output logic                 arb_uplink_ready0,
    output logic                 arb_uplink_ready1,
    output logic                 arb_uplink_ready2,
    output logic [1:0]           arb_ch_chosen,
    output logic [FIFO_WIDE-1:0] arb_data_out
);

    localparam int NCH = 3;

    logic [FIFO_WIDE-1:0] ch_data   [NCH];
    logic [1:0]           ch_prio   [NCH];
    logic [NCH-1:0]       ch_valid;
    logic [1:0]           order_idx [NCH];
    logic [NCH-1:0]       uplink_ready;

    logic                 win_found;
    logic [1:0]           win_idx;
    logic [1:0]           win_prio;
    logic                 grant;

    logic [FIFO_WIDE-1:0] data_out_reg;
    logic [1:0]           ch_chosen_reg;
    logic                 downlink_ready_reg;

    genvar gi;

    assign ch_data[0] = arb_ch0_data_in;
    assign ch_data[1] = arb_ch1_data_in;
    assign ch_data[2] = arb_ch2_data_in;
    assign ch_prio[0] = arb_ch0_priority;
    assign ch_prio[1] = arb_ch1_priority;
    assign ch_prio[2] = arb_ch2_priority;
    assign ch_valid   = {arb_uplink_valid2, arb_uplink_valid1, arb_uplink_valid0};

`ifdef ARB_RR_TIE_EN
    logic [1:0] rr_ptr_reg;
    logic [1:0] rr_start;

    function automatic logic [1:0] idx_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    // Search order begins one past the last granted channel, wrapping 2 -> 0.
    assign rr_start = (rr_ptr_reg == 2'd2) ? 2'd0 : rr_ptr_reg + 2'd1;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rr_order
            assign order_idx[gi] = idx_add(rr_start, 2'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 2'd2;
        end else if (grant) begin
            rr_ptr_reg <= win_idx;
        end
    end
`else
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_fixed_order
            assign order_idx[gi] = 2'(gi);
        end
    endgenerate
`endif

    // Strict less-than keeps the earliest channel in search order among equal priorities.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        win_prio  = 2'd3;
        for (int k = 0; k < NCH; k++) begin
            if (ch_valid[order_idx[k]] &&
                (!win_found || (ch_prio[order_idx[k]] < win_prio))) begin
                win_found = 1'b1;
                win_idx   = order_idx[k];
                win_prio  = ch_prio[order_idx[k]];
            end
        end
    end

    // Reset gates the pop strobes so no upstream FIFO is drained while held in reset.
    assign grant = rst_n && arb_downlink_valid && win_found;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_uplink_ready
            assign uplink_ready[gi] = grant && (win_idx == 2'(gi));
        end
    endgenerate

    assign arb_uplink_ready0 = uplink_ready[0];
    assign arb_uplink_ready1 = uplink_ready[1];
    assign arb_uplink_ready2 = uplink_ready[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_reg       <= '0;
            ch_chosen_reg      <= 2'd0;
            downlink_ready_reg <= 1'b0;
        end else begin
            downlink_ready_reg <= grant;
            if (grant) begin
                data_out_reg  <= ch_data[win_idx];
                ch_chosen_reg <= win_idx;
            end
        end
    end

    assign arb_data_out       = data_out_reg;
    assign arb_ch_chosen      = ch_chosen_reg;
    assign arb_downlink_ready = downlink_ready_reg;

endmodule

// File: tb/tb_mcdf_arbiter.sv
// tb_mcdf_arbiter: directed-vector bench for mcdf_arbiter; works with or without ARB_RR_TIE_EN defined.
`timescale 1ns/1ps
module tb_mcdf_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  arb_ch0_priority, arb_ch1_priority, arb_ch2_priority;
    logic        arb_uplink_valid0, arb_uplink_valid1, arb_uplink_valid2;
    logic        arb_downlink_valid;
    logic [31:0] arb_ch0_data_in, arb_ch1_data_in, arb_ch2_data_in;
    logic        arb_downlink_ready;
    logic        arb_uplink_ready0, arb_uplink_ready1, arb_uplink_ready2;
    logic [1:0]  arb_ch_chosen;
    logic [31:0] arb_data_out;

    int total = 0;
    int bad   = 0;
    int tb_last = 2;

    mcdf_arbiter #(.FIFO_WIDE(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .arb_ch0_priority   (arb_ch0_priority),
        .arb_ch1_priority   (arb_ch1_priority),
        .arb_ch2_priority   (arb_ch2_priority),
        .arb_uplink_valid0  (arb_uplink_valid0),
        .arb_uplink_valid1  (arb_uplink_valid1),
        .arb_uplink_valid2  (arb_uplink_valid2),
        .arb_downlink_valid (arb_downlink_valid),
        .arb_ch0_data_in    (arb_ch0_data_in),
        .arb_ch1_data_in    (arb_ch1_data_in),
        .arb_ch2_data_in    (arb_ch2_data_in),
        .arb_downlink_ready (arb_downlink_ready),
        .arb_uplink_ready0  (arb_uplink_ready0),
        .arb_uplink_ready1  (arb_uplink_ready1),
        .arb_uplink_ready2  (arb_uplink_ready2),
        .arb_ch_chosen      (arb_ch_chosen),
        .arb_data_out       (arb_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_prio(input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2);
        arb_ch0_priority = p0;
        arb_ch1_priority = p1;
        arb_ch2_priority = p2;
    endtask

    task automatic set_valid(input logic [2:0] v);
        {arb_uplink_valid2, arb_uplink_valid1, arb_uplink_valid0} = v;
    endtask

    // Entered just after a rising edge with inputs already applied: check pop strobes
    // mid-cycle, then the registered output stage just after the next edge.
    task automatic run_cycle(input string tag, input logic [2:0] exp_ready, input logic exp_dr,
                             input logic [1:0] exp_ch, input logic [31:0] exp_data);
        logic [2:0] rdy;
        #4;
        rdy = {arb_uplink_ready2, arb_uplink_ready1, arb_uplink_ready0};
        check({tag, ".ready"}, 32'(rdy), 32'(exp_ready));
        check({tag, ".onehot"}, 32'($countones(rdy) <= 1), 32'd1);
        @(posedge clk);
        #1;
        check({tag, ".dl_ready"}, 32'(arb_downlink_ready), 32'(exp_dr));
        check({tag, ".chosen"}, 32'(arb_ch_chosen), 32'(exp_ch));
        check({tag, ".data"}, arb_data_out, exp_data);
        if (exp_dr)
            tb_last = int'(exp_ch);
        $display("%-8s rdy=%b dl_ready=%b ch=%0d data=%h last=%0d", tag, rdy,
                 arb_downlink_ready, arb_ch_chosen, arb_data_out, tb_last);
    endtask

    // Reference winner: smallest priority among valid channels, ties resolved by search order.
    function automatic logic [1:0] model_winner(input logic [2:0] v, input logic [5:0] pcat);
        int p[3];
        int best;
        int start;
        int idx;
        p[0] = int'(pcat[5:4]);
        p[1] = int'(pcat[3:2]);
        p[2] = int'(pcat[1:0]);
        best = 4;
        for (int i = 0; i < 3; i++)
            if (v[i] && p[i] < best) best = p[i];
`ifdef ARB_RR_TIE_EN
        start = (tb_last + 1) % 3;
`else
        start = 0;
`endif
        for (int k = 0; k < 3; k++) begin
            idx = (start + k) % 3;
            if (v[idx] && p[idx] == best) return 2'(idx);
        end
        return 2'd0;
    endfunction

    initial begin
        logic [1:0]  w;
        logic [5:0]  pcat;
        logic [1:0]  tie_ch;

        rst_n = 1'b0;
        set_valid(3'b111);
        set_prio(2'd0, 2'd0, 2'd0);
        arb_downlink_valid = 1'b1;
        arb_ch0_data_in = 32'h1111_1111;
        arb_ch1_data_in = 32'h2222_2222;
        arb_ch2_data_in = 32'h3333_3333;

        #100;
        check("rst.data", arb_data_out, 32'd0);
        check("rst.chosen", 32'(arb_ch_chosen), 32'd0);
        check("rst.dl_ready", 32'(arb_downlink_ready), 32'd0);
        check("rst.ready", 32'({arb_uplink_ready2, arb_uplink_ready1, arb_uplink_ready0}), 32'd0);
        rst_n = 1'b1;

        // Only ch0 valid, and it carries the worst priority: still the only candidate.
        set_valid(3'b001);
        set_prio(2'd3, 2'd0, 2'd0);
        for (int i = 0; i < 6; i++) begin
            arb_ch0_data_in = 32'(i);
            run_cycle("single", 3'b001, 1'b1, 2'd0, 32'(i));
        end

        set_valid(3'b111);
        set_prio(2'd2, 2'd1, 2'd3);
        for (int i = 0; i < 5; i++) begin
            arb_ch0_data_in = 32'hA0 + 32'(i);
            arb_ch1_data_in = 32'd13 + 32'(i);
            arb_ch2_data_in = 32'hB0 + 32'(i);
            run_cycle("prio", 3'b010, 1'b1, 2'd1, 32'd13 + 32'(i));
        end

        arb_downlink_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            arb_ch1_data_in = 32'd50 + 32'(i);
            run_cycle("bpress", 3'b000, 1'b0, 2'd1, 32'd17);
        end
        arb_downlink_valid = 1'b1;
        arb_ch1_data_in = 32'd100;
        run_cycle("resume", 3'b010, 1'b1, 2'd1, 32'd100);

        set_valid(3'b000);
        for (int i = 0; i < 2; i++)
            run_cycle("idle", 3'b000, 1'b0, 2'd1, 32'd100);

        // Last grant was ch1, so a round-robin search starts at ch2.
        set_valid(3'b111);
        set_prio(2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 6; i++) begin
`ifdef ARB_RR_TIE_EN
            tie_ch = 2'((2 + i) % 3);
`else
            tie_ch = 2'd0;
`endif
            arb_ch0_data_in = 32'h1000_0000 + 32'(i);
            arb_ch1_data_in = 32'h2000_0000 + 32'(i);
            arb_ch2_data_in = 32'h3000_0000 + 32'(i);
            run_cycle("tie", 3'b001 << tie_ch, 1'b1, tie_ch,
                      ((32'(tie_ch) + 32'd1) << 28) + 32'(i));
        end

        for (int c = 0; c < 512; c++) begin
            pcat = 6'(c / 8);
            set_prio(pcat[5:4], pcat[3:2], pcat[1:0]);
            arb_ch0_data_in = 32'hC000_0000 + 32'(c);
            arb_ch1_data_in = 32'hC100_0000 + 32'(c);
            arb_ch2_data_in = 32'hC200_0000 + 32'(c);
            w = model_winner(3'b111, pcat);
            run_cycle("dyn", 3'b001 << w, 1'b1, w, 32'hC000_0000 + (32'(w) << 24) + 32'(c));
        end

        // Asynchronous reset mid-cycle must clear the output stage without waiting for an edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst.data", arb_data_out, 32'd0);
        check("mrst.chosen", 32'(arb_ch_chosen), 32'd0);
        check("mrst.dl_ready", 32'(arb_downlink_ready), 32'd0);
        check("mrst.ready", 32'({arb_uplink_ready2, arb_uplink_ready1, arb_uplink_ready0}), 32'd0);
        arb_downlink_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tb_last = 2;

        arb_downlink_valid = 1'b1;
        set_prio(2'd1, 2'd1, 2'd1);
        arb_ch0_data_in = 32'h0000_5A5A;
        arb_ch1_data_in = 32'h0000_6B6B;
        arb_ch2_data_in = 32'h0000_7C7C;
        run_cycle("postrst", 3'b001, 1'b1, 2'd0, 32'h0000_5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
